issue_scoreboard_arbiter: RTL and testbench
===========================================

Name: issue_scoreboard_arbiter

Overview:
Next-generation in-order multi-issue arbiter for the OOO core front end. It decides each cycle how many head-of-queue instructions to issue. Hazard tracking persists across cycles through a register scoreboard (RAW/WAW) and per-functional-unit reservation-station credit counters. This allows several instructions to the same unit type per cycle when credits permit. It sits between the decode queue and the reservation stations, and is woken by the writeback broadcast bus.

Parameters:
MULTI_ISSUE, 3, max instructions issued per cycle (queue slots examined)
NUM_FU, 8, number of functional-unit types (station index width = $clog2(NUM_FU))
STATION_DEPTH, 2, reservation-station entries per unit type (initial/max credits)
WB_PORTS, 2, writeback broadcast ports that clear scoreboard bits
NUM_REGS, 32, architectural registers; register 0 is hardwired zero

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall_i  in  1  suppress all issue this cycle
flush_i  in  1  pipeline flush; cancels all in-flight state
queue_rdy_cnt_i  in  $clog2(MULTI_ISSUE)+1  valid slots at queue head
queue_rd_i/rs1_i/rs2_i  in  [MULTI_ISSUE] x 5  register fields per slot
queue_has_rd_i/rs1_i/rs2_i  in  [MULTI_ISSUE] x 1  operand-present flags per slot
queue_station_i  in  [MULTI_ISSUE] x $clog2(NUM_FU)  target unit type
wb_valid_i  in  [WB_PORTS] x 1  writeback valid
wb_rd_i  in  [WB_PORTS] x 5  writeback destination
fu_release_i  in  NUM_FU  one station entry freed per unit type this cycle
issue_en_o  out  [MULTI_ISSUE] x 1  slot i issues this cycle
issue_cnt_o  out  $clog2(MULTI_ISSUE)+1  number of issued slots (prefix length)
sb_busy_o  out  NUM_REGS  registered scoreboard (pending destinations)
credit_err_o  out  1  sticky: release received with credits already full

Behaviour:
- Reset (async): scoreboard all 0, every credit = STATION_DEPTH, credit_err_o = 0. Outputs issue_en_o = 0 and issue_cnt_o = 0 while rst is high.
- Issue decision is combinational from registered state plus the current inputs. State updates on posedge clk.
- Slots are evaluated in order 0..MULTI_ISSUE-1. Slot i issues only if all of the following hold:
  - no earlier slot blocked;
  - i < queue_rdy_cnt_i;
  - !stall_i and !flush_i;
  - rs1/rs2 (when present, and non-zero) are not busy in the scoreboard and not written by an earlier issuing slot this cycle;
  - rd (when present, non-zero) is not busy in the scoreboard and not written by an earlier issuing slot (WAW);
  - credit[station] > number of earlier slots issued to the same station this cycle.
- The first blocked slot blocks all later slots. issue_en_o is therefore always a prefix and issue_cnt_o equals its popcount.
- Writeback does NOT bypass the issue check. A wb clear becomes visible the cycle after wb_valid_i.
- Scoreboard next state, per register r != 0:
  - set if an issued slot has rd == r;
  - else clear if any wb port has valid with wb_rd == r;
  - else hold.
  - Issue-set wins over a same-cycle wb-clear. Register 0 is never set.
- Credit next state, per unit: credit − issued_to_unit + fu_release_i[unit]. Same-cycle issue and release net out.
  - If the result would exceed STATION_DEPTH, saturate at STATION_DEPTH and set credit_err_o.
  - Credit never goes below 0 (guaranteed by the issue rule).
- flush_i: issue suppressed that cycle. Next state is scoreboard = 0 and all credits = STATION_DEPTH; same-cycle wb and release are ignored. credit_err_o is not cleared by flush, only by rst.
- stall_i: issue suppressed; wb clears and releases still apply.
- Reset asserted mid-cycle clears state immediately, regardless of clk.

Test Plan:
- Reset, then 3 ready slots (ALU rd=1, MUL rd=2, LSU rd=3), all credits available -> issue_en_o=1,1,1, issue_cnt_o=3. Next cycle sb_busy_o=0x0000000E.
- Slot0 writes rd=5, slot1 reads rs1=5 -> issue_cnt_o=1. Next cycle slot with rs1=5 is blocked until wb_valid_i with wb_rd=5. It issues the cycle after wb, not the same cycle.
- STATION_DEPTH=2, three slots all to unit 4 with independent regs -> issue_cnt_o=2. Credit[4]=0 next cycle. Further unit-4 issue blocked until fu_release_i[4]=1, then exactly 1 issues.
- Same cycle: slot0 issues rd=7 and wb_rd=7 valid -> sb_busy_o[7]=1 next cycle (set wins). Slot with rd=0 -> bit 0 never set.
- Release to unit 2 with credit already full -> credit stays 2, credit_err_o=1 and stays high through flush. It clears only on rst.
- Busy regs {1,2} and credit[0]=0, then flush_i=1 with 3 ready slots -> issue_cnt_o=0 that cycle. Next cycle sb_busy_o=0, all credits full, and 3 slots issue.

Source files
------------

// File: rtl/issue_scoreboard_arbiter.sv
// In-order multi-issue arbiter: picks the longest issuable prefix of the decode-queue head
// using a register scoreboard (RAW/WAW) and per-unit reservation-station credits.
module issue_scoreboard_arbiter #(
  parameter int MULTI_ISSUE   = 3,
  parameter int NUM_FU        = 8,
  parameter int STATION_DEPTH = 2,
  parameter int WB_PORTS      = 2,
  parameter int NUM_REGS      = 32,
  localparam int IW = $clog2(MULTI_ISSUE) + 1,
  localparam int SW = $clog2(NUM_FU)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall_i,
  input  logic                               flush_i,
  input  logic [IW-1:0]                      queue_rdy_cnt_i,
  input  logic [MULTI_ISSUE-1:0][4:0]        queue_rd_i,
  input  logic [MULTI_ISSUE-1:0][4:0]        queue_rs1_i,
  input  logic [MULTI_ISSUE-1:0][4:0]        queue_rs2_i,
  input  logic [MULTI_ISSUE-1:0]             queue_has_rd_i,
  input  logic [MULTI_ISSUE-1:0]             queue_has_rs1_i,
  input  logic [MULTI_ISSUE-1:0]             queue_has_rs2_i,
  input  logic [MULTI_ISSUE-1:0][SW-1:0]     queue_station_i,
  input  logic [WB_PORTS-1:0]                wb_valid_i,
  input  logic [WB_PORTS-1:0][4:0]           wb_rd_i,
  input  logic [NUM_FU-1:0]                  fu_release_i,
  output logic [MULTI_ISSUE-1:0]             issue_en_o,
  output logic [IW-1:0]                      issue_cnt_o,
  output logic [NUM_REGS-1:0]                sb_busy_o,
  output logic                               credit_err_o
);

  // Wide enough to hold STATION_DEPTH+1 before saturation and any per-cycle issue count.
  localparam int CW = $clog2(STATION_DEPTH + MULTI_ISSUE + 1) + 1;

  logic [NUM_REGS-1:0]        r_sb, w_sb_nxt, w_pend;
  logic [NUM_FU-1:0][CW-1:0]  r_credit, w_credit_nxt, w_used;
  logic                       r_err, w_err_nxt;
  logic [MULTI_ISSUE-1:0]     w_en;
  logic [IW-1:0]              w_cnt;
  logic                       w_ok, w_blocked;
  logic [CW-1:0]              w_tmp;

  always_comb begin
    w_pend    = '0;
    w_used    = '0;
    w_en      = '0;
    w_cnt     = '0;
    w_ok      = 1'b0;
    w_blocked = rst | stall_i | flush_i;
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      w_ok = !w_blocked && (IW'(i) < queue_rdy_cnt_i);
      // w_pend carries destinations of earlier issuing slots this cycle
      if (queue_has_rs1_i[i] && queue_rs1_i[i] != '0 &&
          (r_sb[queue_rs1_i[i]] || w_pend[queue_rs1_i[i]])) w_ok = 1'b0;
      if (queue_has_rs2_i[i] && queue_rs2_i[i] != '0 &&
          (r_sb[queue_rs2_i[i]] || w_pend[queue_rs2_i[i]])) w_ok = 1'b0;
      if (queue_has_rd_i[i] && queue_rd_i[i] != '0 &&
          (r_sb[queue_rd_i[i]] || w_pend[queue_rd_i[i]])) w_ok = 1'b0;
      if (r_credit[queue_station_i[i]] <= w_used[queue_station_i[i]]) w_ok = 1'b0;
      if (w_ok) begin
        w_en[i] = 1'b1;
        w_cnt   = w_cnt + IW'(1);
        w_used[queue_station_i[i]] = w_used[queue_station_i[i]] + CW'(1);
        if (queue_has_rd_i[i] && queue_rd_i[i] != '0) w_pend[queue_rd_i[i]] = 1'b1;
      end else begin
        w_blocked = 1'b1;
      end
    end
  end

  always_comb begin
    w_sb_nxt     = r_sb;
    w_credit_nxt = r_credit;
    w_err_nxt    = r_err;
    w_tmp        = '0;
    if (flush_i) begin
      w_sb_nxt = '0;
      for (int f = 0; f < NUM_FU; f++) w_credit_nxt[f] = CW'(STATION_DEPTH);
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid_i[p]) w_sb_nxt[wb_rd_i[p]] = 1'b0;
      // issue-set is applied after wb-clear so it wins on the same register
      w_sb_nxt    = w_sb_nxt | w_pend;
      w_sb_nxt[0] = 1'b0;
      for (int f = 0; f < NUM_FU; f++) begin
        w_tmp = r_credit[f] - w_used[f] + {{(CW-1){1'b0}}, fu_release_i[f]};
        if (w_tmp > CW'(STATION_DEPTH)) begin
          w_credit_nxt[f] = CW'(STATION_DEPTH);
          w_err_nxt       = 1'b1;
        end else begin
          w_credit_nxt[f] = w_tmp;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb  <= '0;
      r_err <= 1'b0;
      for (int f = 0; f < NUM_FU; f++) r_credit[f] <= CW'(STATION_DEPTH);
    end else begin
      r_sb     <= w_sb_nxt;
      r_credit <= w_credit_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign issue_en_o   = w_en;
  assign issue_cnt_o  = w_cnt;
  assign sb_busy_o    = r_sb;
  assign credit_err_o = r_err;

endmodule

// File: tb/tb_issue_scoreboard_arbiter.sv
// Directed scoreboard bench: driver pushes hand-computed expectations, negedge monitor compares.
module tb_issue_scoreboard_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_i, flush_i;
  logic [2:0]       queue_rdy_cnt_i;
  logic [2:0][4:0]  queue_rd_i, queue_rs1_i, queue_rs2_i;
  logic [2:0]       queue_has_rd_i, queue_has_rs1_i, queue_has_rs2_i;
  logic [2:0][2:0]  queue_station_i;
  logic [1:0]       wb_valid_i;
  logic [1:0][4:0]  wb_rd_i;
  logic [7:0]       fu_release_i;
  logic [2:0]       issue_en_o;
  logic [2:0]       issue_cnt_o;
  logic [31:0]      sb_busy_o;
  logic             credit_err_o;

  issue_scoreboard_arbiter dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .queue_rdy_cnt_i(queue_rdy_cnt_i),
    .queue_rd_i(queue_rd_i), .queue_rs1_i(queue_rs1_i), .queue_rs2_i(queue_rs2_i),
    .queue_has_rd_i(queue_has_rd_i), .queue_has_rs1_i(queue_has_rs1_i),
    .queue_has_rs2_i(queue_has_rs2_i), .queue_station_i(queue_station_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .fu_release_i(fu_release_i),
    .issue_en_o(issue_en_o), .issue_cnt_o(issue_cnt_o),
    .sb_busy_o(sb_busy_o), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  en;
    logic [2:0]  cnt;
    logic [31:0] sb;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (issue_en_o !== e.en) begin
        n_err++; $display("FAIL %s issue_en got %b want %b", e.name, issue_en_o, e.en);
      end
      if (issue_cnt_o !== e.cnt) begin
        n_err++; $display("FAIL %s issue_cnt got %0d want %0d", e.name, issue_cnt_o, e.cnt);
      end
      if (sb_busy_o !== e.sb) begin
        n_err++; $display("FAIL %s sb_busy got %h want %h", e.name, sb_busy_o, e.sb);
      end
      if (credit_err_o !== e.err) begin
        n_err++; $display("FAIL %s credit_err got %b want %b", e.name, credit_err_o, e.err);
      end
    end
  end

  task automatic clr_in();
    stall_i = 0; flush_i = 0; queue_rdy_cnt_i = 0;
    queue_rd_i = '0; queue_rs1_i = '0; queue_rs2_i = '0;
    queue_has_rd_i = '0; queue_has_rs1_i = '0; queue_has_rs2_i = '0;
    queue_station_i = '0; wb_valid_i = '0; wb_rd_i = '0; fu_release_i = '0;
  endtask

  // Source operands count as present when non-zero.
  task automatic slot(input int i, input logic hrd, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] st);
    queue_has_rd_i[i] = hrd;  queue_rd_i[i] = rd;
    queue_has_rs1_i[i] = (rs1 != 0); queue_rs1_i[i] = rs1;
    queue_has_rs2_i[i] = (rs2 != 0); queue_rs2_i[i] = rs2;
    queue_station_i[i] = st;
  endtask

  task automatic wb(input int p, input logic [4:0] r);
    wb_valid_i[p] = 1'b1; wb_rd_i[p] = r;
  endtask

  // Expectation covers combinational outputs for the current inputs and registered state before this edge.
  task automatic cyc(input string name, input logic [2:0] en, input logic [2:0] cnt,
                     input logic [31:0] sb, input logic err);
    exp_t e;
    e.name = name; e.en = en; e.cnt = cnt; e.sb = sb; e.err = err;
    q.push_back(e);
    @(posedge clk); #1;
    clr_in();
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    @(posedge clk); #1;
    queue_rdy_cnt_i = 3;
    slot(0, 1, 1, 0, 0, 0); slot(1, 1, 2, 0, 0, 1); slot(2, 1, 3, 0, 0, 2);
    cyc("reset_hold", 3'b000, 0, 32'h0, 0);
    rst = 1'b0;

    queue_rdy_cnt_i = 3;
    slot(0, 1, 1, 0, 0, 0); slot(1, 1, 2, 0, 0, 1); slot(2, 1, 3, 0, 0, 2);
    cyc("three_units", 3'b111, 3, 32'h0, 0);
    wb(0, 1); wb(1, 2); fu_release_i = 8'b0000_0111;
    cyc("sb_after_issue", 3'b000, 0, 32'h0000_000E, 0);
    wb(0, 3);
    cyc("wb_clear_12", 3'b000, 0, 32'h0000_0008, 0);

    queue_rdy_cnt_i = 3;
    slot(0, 1, 5, 0, 0, 0); slot(1, 1, 6, 5, 0, 1); slot(2, 1, 7, 0, 0, 2);
    cyc("raw_in_cycle", 3'b001, 1, 32'h0, 0);
    queue_rdy_cnt_i = 1; slot(0, 1, 6, 5, 0, 1); wb(0, 5);
    cyc("raw_wb_no_bypass", 3'b000, 0, 32'h0000_0020, 0);
    queue_rdy_cnt_i = 1; slot(0, 1, 6, 5, 0, 1); fu_release_i[0] = 1'b1;
    cyc("raw_after_wb", 3'b001, 1, 32'h0, 0);

    queue_rdy_cnt_i = 3;
    slot(0, 1, 8, 0, 0, 4); slot(1, 1, 9, 0, 0, 4); slot(2, 1, 10, 0, 0, 4);
    cyc("credit_limit", 3'b011, 2, 32'h0000_0040, 0);
    queue_rdy_cnt_i = 1; slot(0, 1, 11, 0, 0, 4);
    cyc("credit_zero", 3'b000, 0, 32'h0000_0340, 0);
    queue_rdy_cnt_i = 2; slot(0, 1, 11, 0, 0, 4); slot(1, 1, 12, 0, 0, 4);
    fu_release_i[4] = 1'b1;
    cyc("release_not_yet", 3'b000, 0, 32'h0000_0340, 0);
    queue_rdy_cnt_i = 2; slot(0, 1, 11, 0, 0, 4); slot(1, 1, 12, 0, 0, 4);
    cyc("release_one", 3'b001, 1, 32'h0000_0340, 0);

    queue_rdy_cnt_i = 2; slot(0, 1, 7, 0, 0, 0); slot(1, 1, 0, 0, 0, 0); wb(0, 7);
    cyc("set_wins_rd0", 3'b011, 2, 32'h0000_0B40, 0);
    fu_release_i[2] = 1'b1;
    cyc("release_full", 3'b000, 0, 32'h0000_0BC0, 0);

    flush_i = 1; queue_rdy_cnt_i = 3;
    slot(0, 1, 1, 9, 0, 0); slot(1, 1, 2, 0, 11, 0); slot(2, 1, 3, 0, 0, 1);
    wb(0, 9); fu_release_i = 8'b0000_1001;
    cyc("flush_cycle", 3'b000, 0, 32'h0000_0BC0, 1);
    queue_rdy_cnt_i = 3;
    slot(0, 1, 1, 9, 0, 0); slot(1, 1, 2, 0, 11, 0); slot(2, 1, 3, 0, 0, 1);
    cyc("after_flush", 3'b111, 3, 32'h0, 1);

    stall_i = 1; queue_rdy_cnt_i = 1; slot(0, 1, 4, 0, 0, 2); wb(0, 1);
    cyc("stall_wb", 3'b000, 0, 32'h0000_000E, 1);
    queue_rdy_cnt_i = 1; slot(0, 1, 2, 0, 0, 2);
    cyc("waw_sb", 3'b000, 0, 32'h0000_000C, 1);
    queue_rdy_cnt_i = 2; slot(0, 1, 13, 0, 0, 3); slot(1, 1, 13, 0, 0, 3);
    cyc("waw_in_cycle", 3'b001, 1, 32'h0000_000C, 1);

    rst = 1'b1; queue_rdy_cnt_i = 1; slot(0, 1, 14, 0, 0, 3);
    cyc("async_reset", 3'b000, 0, 32'h0, 0);
    rst = 1'b0;
    queue_rdy_cnt_i = 3;
    slot(0, 1, 1, 0, 0, 5); slot(1, 1, 2, 0, 0, 5); slot(2, 1, 3, 0, 0, 5);
    cyc("post_reset_credit", 3'b011, 2, 32'h0, 0);
    queue_rdy_cnt_i = 2;
    slot(0, 1, 20, 0, 0, 6); slot(1, 1, 21, 0, 0, 7); slot(2, 1, 22, 0, 0, 6);
    cyc("rdy_cnt_bound", 3'b011, 2, 32'h0000_0006, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
